// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: active-low {g,f,e,d,c,b,a} patterns for hex digits.
package sevenseg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'b1111111;

    localparam seg_t SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low segment pattern lookup.
module hex_to_seg
    import sevenseg_pkg::*;
(
    input  logic [3:0] i_nib,
    output seg_t       o_seg
);

    assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/sevenseg_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with frame-synchronous
// data updates, blanking, optional leading-zero suppression and anode dead-time.
module sevenseg_scanner
    import sevenseg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int PRESCALE    = 65536,
    parameter int DEADTIME    = 256,
    parameter int LZ_SUPPRESS = 0
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   DIN,
    input  logic [DIGITS-1:0]     DP_IN,
    input  logic [DIGITS-1:0]     BLANK,
    output logic [DIGITS-1:0]     SS_AN,
    output logic [6:0]            SS_SEG,
    output logic                  SS_DP,
    output logic                  FRAME
);

    localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] DT_END   = CW'(DEADTIME);
    localparam logic [DW-1:0] IDX_LAST = DW'(DIGITS - 1);

    logic [CW-1:0]          r_cnt;
    logic [DW-1:0]          r_idx;
    logic [4*DIGITS-1:0]    r_pend_din;
    logic [DIGITS-1:0]      r_pend_dp;
    logic [DIGITS-1:0]      r_pend_blank;
    logic [4*DIGITS-1:0]    r_act_din;
    logic [DIGITS-1:0]      r_act_dp;
    logic [DIGITS-1:0]      r_act_blank;
    logic [DIGITS-1:0]      r_an;
    seg_t                   r_seg;
    logic                   r_dp;
    logic                   r_frame;

    logic                   w_slot_end;
    logic                   w_frame_end;
    logic [3:0]             w_nib;
    seg_t                   w_seg_raw;
    logic [DIGITS-1:0]      w_supp;
    logic                   w_dark;
    logic [DIGITS-1:0]      w_an;
    seg_t                   w_seg;
    logic                   w_dp;

    assign w_slot_end  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);

    // Slot counter and digit index
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= w_frame_end ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            r_idx <= r_idx;
        end
    end

    // Pending register set: last LOAD in a frame wins
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_pend_din   <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
        end else if (LOAD) begin
            r_pend_din   <= DIN;
            r_pend_dp    <= DP_IN;
            r_pend_blank <= BLANK;
        end else begin
            r_pend_din   <= r_pend_din;
            r_pend_dp    <= r_pend_dp;
            r_pend_blank <= r_pend_blank;
        end
    end

    // Active register set: swapped only at the frame boundary, a coincident LOAD bypasses pending
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_act_din   <= '0;
            r_act_dp    <= '0;
            r_act_blank <= '0;
        end else if (w_frame_end) begin
            r_act_din   <= LOAD ? DIN   : r_pend_din;
            r_act_dp    <= LOAD ? DP_IN : r_pend_dp;
            r_act_blank <= LOAD ? BLANK : r_pend_blank;
        end else begin
            r_act_din   <= r_act_din;
            r_act_dp    <= r_act_dp;
            r_act_blank <= r_act_blank;
        end
    end

    assign w_nib = r_act_din[{r_idx, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .i_nib (w_nib),
        .o_seg (w_seg_raw)
    );

    // Leading-zero mask: a digit is suppressed while every nibble from it upward is zero
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        w_supp   = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run  = zero_run & (r_act_din[4*k +: 4] == 4'h0);
            w_supp[k] = zero_run & (k != 0) & (LZ_SUPPRESS != 0);
        end
    end

    assign w_dark = r_act_blank[r_idx] | w_supp[r_idx];

    // Next pin values for the current slot
    always_comb begin
        w_an = '1;
        if (r_cnt >= DT_END) begin
            w_an[r_idx] = 1'b0;
        end else begin
            w_an = '1;
        end
        if (w_dark) begin
            w_seg = SEG_OFF;
            w_dp  = 1'b1;
        end else begin
            w_seg = w_seg_raw;
            w_dp  = ~r_act_dp[r_idx];
        end
    end

    // Registered pin drivers
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_an    <= '1;
            r_seg   <= SEG_OFF;
            r_dp    <= 1'b1;
            r_frame <= 1'b0;
        end else begin
            r_an    <= w_an;
            r_seg   <= w_seg;
            r_dp    <= w_dp;
            r_frame <= w_frame_end;
        end
    end

    assign SS_AN  = r_an;
    assign SS_SEG = r_seg;
    assign SS_DP  = r_dp;
    assign FRAME  = r_frame;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Scoreboard bench for sevenseg_scanner: 4 digits, 4-cycle slots, 1-cycle dead-time,
// one instance without and one with leading-zero suppression sharing the same inputs.
module tb_sevenseg_scanner;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       frame;
    } out_t;

    typedef struct packed {
        out_t        e;
        out_t        m;
        logic        lz;
        logic [15:0] kk;
    } sb_t;

    localparam out_t R_OUT  = 13'b1111_1111111_1_0;
    localparam out_t M_ALL  = 13'b1111_1111111_1_1;
    localparam out_t M_SCAN = 13'b1111_0000000_0_1;
    localparam logic [6:0] S_OFF = 7'b1111111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0001110;

    logic        CLK   = 1'b0;
    logic        RSTN  = 1'b0;
    logic        LOAD  = 1'b0;
    logic [15:0] DIN   = 16'h0000;
    logic [3:0]  DP_IN = 4'b0000;
    logic [3:0]  BLANK = 4'b0000;

    logic [3:0] an_a, an_l;
    logic [6:0] seg_a, seg_l;
    logic       dp_a, dp_l, fr_a, fr_l;
    out_t       obs_a, obs_l;

    sb_t sb_q[$];
    int  k;
    int  n_chk  = 0;
    int  n_pass = 0;

    always #5 CLK = ~CLK;

    sevenseg_scanner #(.DIGITS(4), .PRESCALE(4), .DEADTIME(1), .LZ_SUPPRESS(0)) u_dut (
        .CLK(CLK), .RSTN(RSTN), .LOAD(LOAD), .DIN(DIN), .DP_IN(DP_IN), .BLANK(BLANK),
        .SS_AN(an_a), .SS_SEG(seg_a), .SS_DP(dp_a), .FRAME(fr_a)
    );

    sevenseg_scanner #(.DIGITS(4), .PRESCALE(4), .DEADTIME(1), .LZ_SUPPRESS(1)) u_dut_lz (
        .CLK(CLK), .RSTN(RSTN), .LOAD(LOAD), .DIN(DIN), .DP_IN(DP_IN), .BLANK(BLANK),
        .SS_AN(an_l), .SS_SEG(seg_l), .SS_DP(dp_l), .FRAME(fr_l)
    );

    assign obs_a = {an_a, seg_a, dp_a, fr_a};
    assign obs_l = {an_l, seg_l, dp_l, fr_l};

    // Expected pins kk cycles after reset release: they show slot state kk-1
    function automatic out_t exp_scan(int kk, logic [27:0] segs, logic [3:0] dp_n);
        out_t r;
        int   c;
        int   d;
        c       = (kk - 1) % 4;
        d       = ((kk - 1) / 4) % 4;
        r.an    = (c == 0) ? 4'b1111 : ~(4'b0001 << d);
        r.seg   = segs[d*7 +: 7];
        r.dp    = dp_n[d];
        r.frame = ((kk % 16) == 0);
        return r;
    endfunction

    task automatic push_win(int k0, int k1, logic [27:0] segs, logic [3:0] dp_n, logic lz, out_t m);
        for (int kk = k0; kk <= k1; kk++) begin
            sb_q.push_back('{e: exp_scan(kk, segs, dp_n), m: m, lz: lz, kk: 16'(kk)});
        end
    endtask

    task automatic push_reset(int kk);
        sb_q.push_back('{e: R_OUT, m: M_ALL, lz: 1'b0, kk: 16'(kk)});
        sb_q.push_back('{e: R_OUT, m: M_ALL, lz: 1'b1, kk: 16'(kk)});
    endtask

    task automatic tick();
        @(negedge CLK);
        k = k + 1;
    endtask

    task automatic test_reset();
        sb_t  s;
        out_t o;
        RSTN = 1'b0;
        k    = 0;
        for (int i = 1; i <= 6; i++) push_reset(i);
        for (int i = 0; i < 6; i++) begin
            if (i < 5) tick();
            else begin
                RSTN = 1'b1;
                k    = k + 1;
                #1;
            end
            for (int j = 0; j < sb_q.size(); ) begin
                if (sb_q[j].kk == 16'(k)) begin
                    s = sb_q[j];
                    sb_q.delete(j);
                    o = s.lz ? obs_l : obs_a;
                    n_chk++;
                    if (((o ^ s.e) & s.m) !== 13'd0)
                        $display("FAIL reset step=%0d lz=%0d: got %b want %b", k, s.lz, o, s.e);
                    else n_pass++;
                end else j++;
            end
        end
        k = 0;
    endtask

    task automatic test_scan();
        sb_t s;
        push_win(1, 32, {S0, S0, S0, S0}, 4'b1111, 1'b0, M_SCAN);
        for (int i = 0; i < 32; i++) begin
            tick();
            s = sb_q.pop_front();
            n_chk++;
            if (((obs_a ^ s.e) & s.m) !== 13'd0 || s.kk != 16'(k))
                $display("FAIL scan k=%0d: got %b want %b", k, obs_a, s.e);
            else n_pass++;
        end
    endtask

    task automatic test_decode();
        sb_t s;
        LOAD = 1'b1; DIN = 16'h1A8F; DP_IN = 4'b0010; BLANK = 4'b0000;
        push_win(33, 48, {S0, S0, S0, S0}, 4'b1111, 1'b0, M_ALL);
        push_win(49, 64, {S1, SA, S8, SF}, 4'b1101, 1'b0, M_ALL);
        for (int i = 0; i < 32; i++) begin
            tick();
            LOAD = 1'b0;
            s = sb_q.pop_front();
            n_chk++;
            if ((obs_a ^ s.e) !== 13'd0 || s.kk != 16'(k))
                $display("FAIL decode k=%0d: got %b want %b", k, obs_a, s.e);
            else n_pass++;
        end
    endtask

    task automatic test_tear_free();
        sb_t s;
        LOAD = 1'b1; DIN = 16'h0000; DP_IN = 4'b0000;
        push_win(65, 80, {S1, SA, S8, SF}, 4'b1101, 1'b0, M_ALL);
        push_win(81, 96, {S0, S0, S0, S0}, 4'b1111, 1'b0, M_ALL);
        push_win(97, 112, {S1, S1, S1, S1}, 4'b1111, 1'b0, M_ALL);
        push_win(113, 128, {S2, S2, S2, S2}, 4'b1111, 1'b0, M_ALL);
        for (int i = 0; i < 64; i++) begin
            tick();
            LOAD = 1'b0;
            if (k == 88) begin
                LOAD = 1'b1; DIN = 16'h1111;
            end
            if (k == 111) begin
                LOAD = 1'b1; DIN = 16'h2222;
            end
            s = sb_q.pop_front();
            n_chk++;
            if ((obs_a ^ s.e) !== 13'd0 || s.kk != 16'(k))
                $display("FAIL tear_free k=%0d: got %b want %b", k, obs_a, s.e);
            else n_pass++;
        end
    endtask

    task automatic test_lz_blank();
        sb_t  s;
        out_t o;
        LOAD = 1'b1; DIN = 16'h0070; DP_IN = 4'b0100; BLANK = 4'b0001;
        push_win(129, 144, {S2, S2, S2, S2}, 4'b1111, 1'b0, M_ALL);
        push_win(145, 176, {S0, S0, S7, S_OFF}, 4'b1011, 1'b0, M_ALL);
        push_win(145, 176, {S_OFF, S_OFF, S7, S_OFF}, 4'b1111, 1'b1, M_ALL);
        push_win(177, 192, {S_OFF, S_OFF, S_OFF, S0}, 4'b1111, 1'b1, M_ALL);
        for (int i = 0; i < 64; i++) begin
            tick();
            LOAD = 1'b0;
            if (k == 160) begin
                LOAD = 1'b1; DIN = 16'h0000; DP_IN = 4'b0000; BLANK = 4'b0000;
            end
            for (int j = 0; j < sb_q.size(); ) begin
                if (sb_q[j].kk == 16'(k)) begin
                    s = sb_q[j];
                    sb_q.delete(j);
                    o = s.lz ? obs_l : obs_a;
                    n_chk++;
                    if ((o ^ s.e) !== 13'd0)
                        $display("FAIL lz_blank k=%0d lz=%0d: got %b want %b", k, s.lz, o, s.e);
                    else n_pass++;
                end else j++;
            end
        end
    endtask

    task automatic test_reset_midframe();
        sb_t  s;
        out_t o;
        LOAD = 1'b1; DIN = 16'h5555; DP_IN = 4'b1111;
        tick();
        LOAD = 1'b0;
        while (k < 203) tick();
        RSTN = 1'b0;
        push_reset(k);
        push_reset(k + 1);
        push_reset(k + 2);
        push_reset(0);
        push_win(1, 20, {S0, S0, S0, S0}, 4'b1111, 1'b0, M_ALL);
        push_win(1, 8, {S_OFF, S_OFF, S_OFF, S0}, 4'b1111, 1'b1, M_ALL);
        #1;
        for (int i = 0; i < 24; i++) begin
            if (i == 1 || i == 2) tick();
            else if (i == 3) begin
                RSTN = 1'b1;
                k    = 0;
                #1;
            end else if (i > 3) tick();
            for (int j = 0; j < sb_q.size(); ) begin
                if (sb_q[j].kk == 16'(k)) begin
                    s = sb_q[j];
                    sb_q.delete(j);
                    o = s.lz ? obs_l : obs_a;
                    n_chk++;
                    if ((o ^ s.e) !== 13'd0)
                        $display("FAIL reset_midframe k=%0d lz=%0d: got %b want %b", k, s.lz, o, s.e);
                    else n_pass++;
                end else j++;
            end
        end
        n_chk++;
        if (sb_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d leftover want 0", sb_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_decode();
        test_tear_free();
        test_lz_blank();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sevenseg_scanner.md
# sevenseg_scanner

Parametrised time-multiplexed seven-segment display driver. It scans `DIGITS` common-anode digits at a configurable slot rate and decodes a packed hex word into segment patterns. Features: per-digit decimal-point and blank masks, optional leading-zero suppression, anode dead-time against ghosting, and tear-free frame-synchronous updates. It sits between display-producing logic and the `SS_AN`/`SS_SEG`/`SS_DP` board pins.

## Interface
- `DIGITS`, 4: number of digits scanned; ≥1.
- `PRESCALE`, 65536: CLK cycles per digit slot; ≥2.
- `DEADTIME`, 256: cycles at slot start with all anodes off; 0 ≤ `DEADTIME` < `PRESCALE`.
- `LZ_SUPPRESS`, 0: 1 = blank leading zero digits.
- `CLK` in 1: single clock; all logic on rising edge.
- `RSTN` in 1: asynchronous, active-low reset.
- `LOAD` in 1: capture `DIN`/`DP_IN`/`BLANK` into the pending register this cycle.
- `DIN` in 4*`DIGITS`: hex nibbles; nibble k (`DIN[4k+3:4k]`) drives digit k; digit 0 is rightmost.
- `DP_IN` in `DIGITS`: 1 = decimal point lit on digit k.
- `BLANK` in `DIGITS`: 1 = digit k fully dark.
- `SS_AN` out `DIGITS`: anode enables, active-low.
- `SS_SEG` out 7: `{g,f,e,d,c,b,a}`, active-low.
- `SS_DP` out 1: decimal point, active-low.
- `FRAME` out 1: one-cycle pulse at each frame boundary.

## Operation
- Slot counter `cnt` counts 0..`PRESCALE`-1 and wraps.
- Digit index `idx` counts 0..`DIGITS`-1 and increments when `cnt`=`PRESCALE`-1.
  - It wraps to 0 after `DIGITS`-1. That wrap is the frame boundary.
- Two register sets: pending (written by `LOAD`) and active (drives display).
  - Pending copies into active only at the frame boundary, so no frame mixes old and new data.
  - `LOAD` on the boundary cycle: active takes the `LOAD` inputs directly (new value wins), and pending is also updated.
  - Several `LOAD`s within one frame: the last one wins.
- Decode per slot, for digit `idx`:
  - Segments are `hex_to_seg`(active nibble).
  - DP lit iff active `DP_IN[idx]`.
  - Digit dark (segments and DP off) if active `BLANK[idx]`, or if suppressed.
- Leading-zero suppression (`LZ_SUPPRESS`=1):
  - Digit k is suppressed iff every nibble from k up to `DIGITS`-1 is 0 and k≠0.
  - Digit 0 always shows.
  - A DP on a suppressed digit is also dark.
- Anode drive:
  - While `cnt` < `DEADTIME`, `SS_AN` is all ones.
  - Otherwise only `SS_AN[idx]`=0.
- Hex patterns (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

## Timing
- All outputs are registered: pins reflect `cnt`/`idx`/active state of the previous cycle (1-cycle latency).
- During reset and on the first cycle after release:
  - `cnt`=0, `idx`=0.
  - Pending and active registers all 0.
  - `SS_AN`=all ones, `SS_SEG`=1111111, `SS_DP`=1, `FRAME`=0.
- First anode assertion: digit 0, on the cycle after `cnt` reaches `DEADTIME`.
  - With `DEADTIME`=0, this is the second cycle after reset release.
- `FRAME` is high for exactly one cycle: the cycle after `cnt`=`PRESCALE`-1 and `idx`=`DIGITS`-1.
  - Period = `DIGITS`*`PRESCALE` cycles.
- `DIGITS`=1: every slot end is a frame boundary.
- Reset mid-frame: all state returns to reset values immediately (asynchronous); pending data is lost.
- Counter widths are `$clog2(PRESCALE)` and `$clog2(DIGITS)`, minimum 1 bit. Neither counter may take an out-of-range value.

## Structure
- Shared package `sevenseg_pkg`:
  - 16-entry active-low segment constant table.
  - `SEG_OFF`=1111111 constant.
  - Segment-vector typedef `seg_t` (7 bits).
- Sub-module `hex_to_seg`: purely combinational nibble→`seg_t` lookup from the package table; reused by other display blocks.
- Top contains the counters, pending/active registers, suppression logic and output registers.

## Test plan
- Reset: hold `RSTN`=0 for 5 cycles → `SS_AN`=1111, `SS_SEG`=1111111, `SS_DP`=1, `FRAME`=0 throughout and on the first cycle after release.
- Scan order (`PRESCALE`=4, `DEADTIME`=1, `DIGITS`=4):
  - `SS_AN` per slot: 1111 for 1 cycle, then 1110 ×3; next slot 1111, 1101 ×3; then 1011, 0111.
  - `FRAME` pulses every 16 cycles.
- Decode: `LOAD` `DIN`=16'h1A8F, `DP_IN`=0010 → after next `FRAME`:
  - digit0 SS_SEG=0001110, digit1=0000000 with SS_DP=0, digit2=0001000, digit3=1111001.
- Tear-free update: `LOAD` 16'h1111 mid-frame after digit 1 has shown 16'h0000 → remaining digits of that frame still show 0; all digits show 1 only from the next frame.
  - `LOAD` on the boundary cycle takes effect in that new frame.
- Suppression/blank (`LZ_SUPPRESS`=1): `DIN`=16'h0070, `BLANK`=0001 → digits 3 and 2 dark, digit 1 shows 1111000, digit 0 dark via `BLANK`; `DIN`=0 → only digit 0 shows 1000000.
- Reset mid-frame: assert `RSTN`=0 during slot 2 → `SS_AN`=1111 at once; after release, scan restarts at digit 0 showing 1000000 (active data cleared).
